seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 153 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
// seg_scan_driver: six-digit multiplexed 7-segment driver for a MM:SS.hh
// stopwatch display. The BCD time is snapshotted once per frame so a frame
// never mixes digits from two different input values. Each digit slot
// starts with a short all-off blanking window to hide anode ghosting.
// All display outputs are registered with one cycle of latency.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,  // clk_core cycles per digit slot (>= 2)
    parameter int BLANK_CYC = 8       // anode-off cycles at slot start (1..SCAN_DIV-1)
) (
    input  logic       clk_core,
    input  logic       rst,           // asynchronous, active-low
    input  logic [7:0] min_i,         // packed BCD {tens,ones}
    input  logic [7:0] sec_i,         // packed BCD {tens,ones}
    input  logic [7:0] ms_10_i,       // packed BCD {tens,ones}, hundredths
    input  logic       lzb,           // blank minutes-tens when it is zero
    output logic [5:0] an,            // active-low anodes, an[0] rightmost
    output logic [6:0] seg,           // active-low {g,f,e,d,c,b,a}
    output logic       dp,            // active-low decimal point
    output logic       frame_o        // one-cycle pulse after snapshot load
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [5:0] AN_OFF   = 6'b111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [23:0]   snap;   // {min, sec, ms_10}; nibble n belongs to digit idx n
    state_t        state;

    state_t        state_nxt;
    logic [3:0]    digit;
    logic [5:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic          frame_nxt;
    logic          slot_end;
    logic          frame_start;

    // BCD digit to active-low gfedcba; anything above 9 shows a dash
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign slot_end    = (cnt == CW'(SCAN_DIV - 1));
    assign frame_start = (cnt == '0) && (idx == 3'd0);

    // Slot/digit scan counters and the per-frame snapshot of the time inputs
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            idx  <= 3'd0;
            snap <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Load happens inside the blanking window, so no shown digit ever
            // changes source mid-slot.
            if (frame_start) begin
                snap <= {min_i, sec_i, ms_10_i};
            end
        end
    end

    // Decode the next display value from the current scan position
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        digit     = 4'h0;
        an_nxt    = AN_OFF;
        seg_nxt   = SEG_OFF;
        dp_nxt    = 1'b1;
        frame_nxt = frame_start;
        state_nxt = (cnt < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;

        case (idx)
            3'd0:    digit = snap[3:0];
            3'd1:    digit = snap[7:4];
            3'd2:    digit = snap[11:8];
            3'd3:    digit = snap[15:12];
            3'd4:    digit = snap[19:16];
            3'd5:    digit = snap[23:20];
            default: digit = 4'h0;
        endcase

        if (state_nxt == ST_SHOW) begin
            an_nxt = ~(6'b000001 << idx);
            // lzb is live, so the blanking can be toggled without waiting a frame
            if ((idx == 3'd5) && lzb && (digit == 4'd0)) begin
                seg_nxt = SEG_OFF;
            end else begin
                seg_nxt = bcd_to_seg(digit);
            end
            // Separators after minutes and after seconds: MM.SS.hh
            dp_nxt = !((idx == 3'd2) || (idx == 3'd4));
        end
    end

    // Blank/show FSM with registered display outputs
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state   <= ST_BLANK;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
            dp      <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            frame_o <= frame_nxt;
            case (state_nxt)
                ST_SHOW: begin
                    an  <= an_nxt;
                    seg <= seg_nxt;
                    dp  <= dp_nxt;
                end
                default: begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                    dp  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
// Bench for seg_scan_driver with SCAN_DIV=4, BLANK_CYC=1 (frame = 24 cycles).
// The stimulus process predicts each post-edge output and queues it; a
// monitor on the falling edge pops and compares against the DUT.
module tb_seg_scan_driver;

    logic       clk_core = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] min_i, sec_i, ms_10_i;
    logic       lzb;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_o;

    seg_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk_core (clk_core),
        .rst      (rst),
        .min_i    (min_i),
        .sec_i    (sec_i),
        .ms_10_i  (ms_10_i),
        .lzb      (lzb),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .frame_o  (frame_o)
    );

    always #5 clk_core = ~clk_core;

    typedef struct packed {
        logic [15:0] k;
        logic [5:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        frame;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    int          k;          // edges since reset release
    logic [23:0] exp_snap;   // model snapshot {min,sec,ms}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-written segment table, gfedcba active-low
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // One clock edge: predict the output after this edge and queue it
    task automatic step();
        exp_t       e;
        int         ph;
        int         ix;
        logic [3:0] nib;
        @(posedge clk_core);
        ph      = k % 4;
        ix      = (k / 4) % 6;
        e.k     = 16'(k);
        e.frame = (k % 24 == 0);
        e.an    = 6'h3F;
        e.seg   = 7'h7F;
        e.dp    = 1'b1;
        if (ph != 0) begin
            e.an[ix] = 1'b0;
            nib      = exp_snap[ix*4 +: 4];
            e.seg    = seg_of(nib);
            if (ix == 5 && lzb && nib == 4'd0) e.seg = 7'h7F;
            e.dp     = !(ix == 2 || ix == 4);
        end
        if (k % 24 == 0) exp_snap = {min_i, sec_i, ms_10_i};
        sb_q.push_back(e);
        k++;
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge
    always @(negedge clk_core) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("an k=%0d", e.k), 32'(an), 32'(e.an));
            check($sformatf("seg k=%0d", e.k), 32'(seg), 32'(e.seg));
            check($sformatf("dp k=%0d", e.k), 32'(dp), 32'(e.dp));
            check($sformatf("frame_o k=%0d", e.k), 32'(frame_o), 32'(e.frame));
            check($sformatf("one_anode k=%0d", e.k), 32'($countones(~an) <= 1), 32'd1);
        end
    end

    // Independent frame period measurement
    int gap  = 0;
    bit seen = 1'b0;
    always @(negedge clk_core) begin
        if (!rst) begin
            gap  = 0;
            seen = 1'b0;
        end else begin
            gap++;
            if (frame_o) begin
                if (seen) check("frame_period", 32'(gap), 32'd24);
                seen = 1'b1;
                gap  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, " an"}, 32'(an), 32'h3F);
        check({tag, " seg"}, 32'(seg), 32'h7F);
        check({tag, " dp"}, 32'(dp), 32'd1);
        check({tag, " frame_o"}, 32'(frame_o), 32'd0);
    endtask

    initial begin
        min_i    = 8'h12;
        sec_i    = 8'h34;
        ms_10_i  = 8'h56;
        lzb      = 1'b0;
        k        = 0;
        exp_snap = '0;

        repeat (2) @(negedge clk_core);
        #1;
        check_reset_outputs("reset");

        // Release away from the rising edge
        rst = 1'b1;

        // Frames 1-4: tearing, lzb and dash cases
        for (int i = 0; i < 96; i++) begin
            step();
            if (i == 9)  sec_i = 8'h59;                     // mid-frame 1 change
            if (i == 24) begin
                min_i   = 8'h05;
                ms_10_i = 8'hA3;
                lzb     = 1'b1;                             // frame 3 blanks min tens
            end
            if (i == 71) lzb = 1'b0;                        // frame 4 shows 0
        end

        // Into frame 5 until mid-SHOW of idx3 (k%24 == 14)
        for (int i = 0; i < 15; i++) step();
        @(negedge clk_core);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        check("queue_empty_at_reset", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk_core);
        #1;
        check_reset_outputs("reset_hold");

        // Fresh frame after release with new values
        min_i    = 8'h00;
        sec_i    = 8'h07;
        ms_10_i  = 8'h99;
        lzb      = 1'b1;
        k        = 0;
        exp_snap = '0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < 48; i++) step();

        @(negedge clk_core);
        #1;
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
